// File: rtl/adc_capture_buffer.sv
// Triggered snapshot buffer for one ADC AXI4-Stream channel: records into a BRAM ring,
// freezes a pre/post-trigger window, then replays it as a TLAST-terminated packet.
module adc_capture_buffer #(
    parameter int ADDR_BITS  = 10,
    parameter int DATA_WIDTH = 128
) (
    input  logic                  aclk,
    input  logic                  aclk_rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    input  logic                  arm,
    input  logic                  trigger,
    input  logic [ADDR_BITS-1:0]  pretrig_len,
    input  logic [ADDR_BITS:0]    capture_len,
    output logic                  armed,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_BITS-1:0]  trig_addr
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS:0] DEPTH_L = (ADDR_BITS+1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_ARMED,
        S_POST,
        S_READOUT,
        S_DONE
    } state_t;

    state_t state_reg, state_next;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_BITS-1:0] wptr_reg;
    logic [ADDR_BITS:0]   precnt_reg, precnt_next;
    logic [ADDR_BITS:0]   postcnt_reg, postcnt_next;
    logic [ADDR_BITS:0]   c_reg, c_next;
    logic [ADDR_BITS-1:0] p_reg, p_next;
    logic [ADDR_BITS-1:0] trig_addr_reg, trig_addr_next;
    logic [ADDR_BITS-1:0] raddr_reg, raddr_next;
    logic [ADDR_BITS:0]   rcnt_reg, rcnt_next;

    logic [ADDR_BITS:0]   c_clamped;
    logic [ADDR_BITS-1:0] p_clamped;
    logic [ADDR_BITS:0]   post_need;
    logic                 wr_en;

    // Read pipeline: two BRAM register stages feeding a two-entry output FIFO
    logic [DATA_WIDTH-1:0] rd1_data_reg, rd2_data_reg;
    logic                  rd1_valid_reg, rd2_valid_reg;
    logic                  rd1_last_reg, rd2_last_reg;
    logic [DATA_WIDTH-1:0] fifo_data_reg [2];
    logic                  fifo_last_reg [2];
    logic                  fifo_wp_reg, fifo_rp_reg;
    logic [1:0]            fifo_count_reg;
    logic                  adv, issue, issue_last, push, pop;

    assign s_axis_tready = 1'b1;

    assign c_clamped = (capture_len == '0 || capture_len > DEPTH_L) ? DEPTH_L : capture_len;
    assign p_clamped = ({1'b0, pretrig_len} >= c_clamped) ? ADDR_BITS'(c_clamped - 1'b1)
                                                          : pretrig_len;
    assign post_need = c_reg - {1'b0, p_reg};

    assign wr_en = s_axis_tvalid &&
                   (state_reg == S_PRE || state_reg == S_ARMED || state_reg == S_POST);

    assign m_axis_tvalid = (fifo_count_reg != 2'd0);
    assign m_axis_tdata  = fifo_data_reg[fifo_rp_reg];
    assign m_axis_tlast  = m_axis_tvalid && fifo_last_reg[fifo_rp_reg];

    assign pop        = m_axis_tvalid && m_axis_tready;
    // The whole read pipeline stalls only when the FIFO is full and nothing leaves it
    assign adv        = (fifo_count_reg != 2'd2) || pop;
    assign issue      = (state_reg == S_READOUT) && adv && (rcnt_reg != c_reg);
    assign issue_last = (rcnt_reg == c_reg - 1'b1);
    assign push       = adv && rd2_valid_reg;

    assign armed     = (state_reg == S_ARMED);
    assign busy      = (state_reg == S_PRE) || (state_reg == S_ARMED) ||
                       (state_reg == S_POST) || (state_reg == S_READOUT);
    assign done      = (state_reg == S_DONE);
    assign trig_addr = trig_addr_reg;

    always_comb begin
        state_next     = state_reg;
        precnt_next    = precnt_reg;
        postcnt_next   = postcnt_reg;
        c_next         = c_reg;
        p_next         = p_reg;
        trig_addr_next = trig_addr_reg;
        raddr_next     = raddr_reg;
        rcnt_next      = rcnt_reg;

        case (state_reg)
            S_IDLE, S_DONE: begin
                if (arm) begin
                    c_next      = c_clamped;
                    p_next      = p_clamped;
                    precnt_next = '0;
                    state_next  = (p_clamped == '0) ? S_ARMED : S_PRE;
                end
            end
            S_PRE: begin
                if (s_axis_tvalid) begin
                    precnt_next = precnt_reg + 1'b1;
                    if (precnt_reg + 1'b1 == {1'b0, p_reg}) begin
                        state_next = S_ARMED;
                    end
                end
            end
            S_ARMED: begin
                if (trigger) begin
                    trig_addr_next = wptr_reg;
                    postcnt_next   = s_axis_tvalid ? (ADDR_BITS+1)'(1) : '0;
                    // A one-beat post window completes on the trigger beat itself
                    if (s_axis_tvalid && post_need == (ADDR_BITS+1)'(1)) begin
                        raddr_next = wptr_reg - p_reg;
                        rcnt_next  = '0;
                        state_next = S_READOUT;
                    end else begin
                        state_next = S_POST;
                    end
                end
            end
            S_POST: begin
                if (s_axis_tvalid) begin
                    postcnt_next = postcnt_reg + 1'b1;
                    if (postcnt_reg + 1'b1 == post_need) begin
                        raddr_next = trig_addr_reg - p_reg;
                        rcnt_next  = '0;
                        state_next = S_READOUT;
                    end
                end
            end
            S_READOUT: begin
                if (issue) begin
                    raddr_next = raddr_reg + 1'b1;
                    rcnt_next  = rcnt_reg + 1'b1;
                end
                if (pop && m_axis_tlast) begin
                    state_next = S_DONE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (aclk_rst) begin
            state_reg     <= S_IDLE;
            wptr_reg      <= '0;
            precnt_reg    <= '0;
            postcnt_reg   <= '0;
            c_reg         <= '0;
            p_reg         <= '0;
            trig_addr_reg <= '0;
            raddr_reg     <= '0;
            rcnt_reg      <= '0;
        end else begin
            state_reg     <= state_next;
            precnt_reg    <= precnt_next;
            postcnt_reg   <= postcnt_next;
            c_reg         <= c_next;
            p_reg         <= p_next;
            trig_addr_reg <= trig_addr_next;
            raddr_reg     <= raddr_next;
            rcnt_reg      <= rcnt_next;
            if (wr_en) begin
                wptr_reg <= wptr_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (wr_en) begin
            mem[wptr_reg] <= s_axis_tdata;
        end
    end

    always_ff @(posedge aclk) begin
        if (adv) begin
            rd1_data_reg <= mem[raddr_reg];
            rd2_data_reg <= rd1_data_reg;
        end
    end

    always_ff @(posedge aclk) begin
        if (push) begin
            fifo_data_reg[fifo_wp_reg] <= rd2_data_reg;
            fifo_last_reg[fifo_wp_reg] <= rd2_last_reg;
        end
    end

    always_ff @(posedge aclk) begin
        if (aclk_rst) begin
            rd1_valid_reg  <= 1'b0;
            rd1_last_reg   <= 1'b0;
            rd2_valid_reg  <= 1'b0;
            rd2_last_reg   <= 1'b0;
            fifo_wp_reg    <= 1'b0;
            fifo_rp_reg    <= 1'b0;
            fifo_count_reg <= 2'd0;
        end else begin
            if (adv) begin
                rd1_valid_reg <= issue;
                rd1_last_reg  <= issue && issue_last;
                rd2_valid_reg <= rd1_valid_reg;
                rd2_last_reg  <= rd1_last_reg;
            end
            if (push) begin
                fifo_wp_reg <= ~fifo_wp_reg;
            end
            if (pop) begin
                fifo_rp_reg <= ~fifo_rp_reg;
            end
            case ({push, pop})
                2'b10:   fifo_count_reg <= fifo_count_reg + 2'd1;
                2'b01:   fifo_count_reg <= fifo_count_reg - 2'd1;
                default: fifo_count_reg <= fifo_count_reg;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_capture_buffer.sv
// Directed bench for adc_capture_buffer with a 64-beat ring; beat k carries k in every lane.
module tb_adc_capture_buffer;

    localparam int AB = 6;
    localparam int DW = 128;

    logic          aclk = 1'b0;
    logic          aclk_rst;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic          arm;
    logic          trigger;
    logic [AB-1:0] pretrig_len;
    logic [AB:0]   capture_len;
    logic          armed;
    logic          busy;
    logic          done;
    logic [AB-1:0] trig_addr;

    always #5 aclk = ~aclk;

    adc_capture_buffer #(.ADDR_BITS(AB), .DATA_WIDTH(DW)) dut (
        .aclk          (aclk),
        .aclk_rst      (aclk_rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .arm           (arm),
        .trigger       (trigger),
        .pretrig_len   (pretrig_len),
        .capture_len   (capture_len),
        .armed         (armed),
        .busy          (busy),
        .done          (done),
        .trig_addr     (trig_addr)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: records accepted beats and flags any change while stalled
    logic [DW-1:0] rx_data [$];
    bit            rx_last [$];
    int            rx_cyc  [$];
    bit            mon_en = 1'b0;
    int            stall_err = 0;
    int            cyc = 0;
    bit            prev_stalled = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    always @(posedge aclk) cyc <= cyc + 1;

    always @(negedge aclk) begin
        if (aclk_rst) begin
            prev_stalled <= 1'b0;
        end else begin
            if (prev_stalled && (!m_axis_tvalid || m_axis_tdata !== prev_data ||
                                 m_axis_tlast !== prev_last)) begin
                stall_err <= stall_err + 1;
            end
            if (mon_en && m_axis_tvalid && m_axis_tready) begin
                rx_data.push_back(m_axis_tdata);
                rx_last.push_back(m_axis_tlast);
                rx_cyc.push_back(cyc);
            end
            prev_stalled <= m_axis_tvalid && !m_axis_tready;
            prev_data    <= m_axis_tdata;
            prev_last    <= m_axis_tlast;
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        aclk_rst      = 1'b1;
        arm           = 1'b0;
        trigger       = 1'b0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        tick();
        tick();
        aclk_rst = 1'b0;
        tick();
    endtask

    // Arms, streams beats from value 0, triggers on the given beat and collects the replay.
    // stop_after >= 0 leaves the loop once that many output beats were accepted.
    task automatic run_capture(input string name, input logic [AB:0] clen, input logic [AB-1:0] plen,
                               input bit arm_trig, input int trig_beat, input int early_beat,
                               input int vpct, input int rpct, input int stop_after);
        int  beat;
        int  n;
        bit  v;
        logic [15:0] b16;
        rx_data.delete();
        rx_last.delete();
        rx_cyc.delete();
        mon_en        = 1'b1;
        capture_len   = clen;
        pretrig_len   = plen;
        arm           = 1'b1;
        trigger       = arm_trig;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        tick();
        arm     = 1'b0;
        trigger = 1'b0;
        check_val({name, "_done_after_arm"}, done, 0);
        check_val({name, "_busy_after_arm"}, busy, 1);
        beat = 0;
        n    = 0;
        while (!done && n < 3000 && !(stop_after >= 0 && rx_data.size() >= stop_after)) begin
            v             = ($urandom_range(99) < vpct);
            b16           = 16'(beat);
            s_axis_tvalid = v;
            s_axis_tdata  = {8{b16}};
            trigger       = v && (beat == trig_beat || beat == early_beat);
            m_axis_tready = ($urandom_range(99) < rpct);
            tick();
            if (v && beat == early_beat) begin
                check_val({name, "_pre_trigger_ignored"}, armed, 0);
            end
            if (v) beat++;
            n++;
        end
        s_axis_tvalid = 1'b0;
        trigger       = 1'b0;
        check_val({name, "_timeout"}, n < 3000, 1);
    endtask

    task automatic check_window(input string name, input int exp_first, input int exp_c,
                                input logic [AB-1:0] exp_taddr, input bit burst);
        logic [15:0] ev;
        check_val({name, "_count"}, rx_data.size(), exp_c);
        for (int i = 0; i < rx_data.size() && i < exp_c; i++) begin
            ev = 16'(exp_first + i);
            check_val($sformatf("%s_data%0d", name, i), rx_data[i], {8{ev}});
            check_val($sformatf("%s_last%0d", name, i), rx_last[i], (i == exp_c - 1));
        end
        check_val({name, "_done"}, done, 1);
        check_val({name, "_busy"}, busy, 0);
        check_val({name, "_tvalid_idle"}, m_axis_tvalid, 0);
        check_val({name, "_trig_addr"}, trig_addr, exp_taddr);
        check_val({name, "_stall_stable"}, stall_err, 0);
        if (burst && rx_data.size() == exp_c) begin
            check_val({name, "_back_to_back"}, rx_cyc[exp_c-1] - rx_cyc[0], exp_c - 1);
        end
    endtask

    initial begin
        bit any_last;
        aclk_rst      = 1'b1;
        arm           = 1'b0;
        trigger       = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        m_axis_tready = 1'b0;
        pretrig_len   = '0;
        capture_len   = '0;
        do_reset();

        check_val("rst_tvalid", m_axis_tvalid, 0);
        check_val("rst_tlast", m_axis_tlast, 0);
        check_val("rst_armed", armed, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_trig_addr", trig_addr, 0);
        check_val("rst_tready", s_axis_tready, 1);

        run_capture("basic", 7'd16, 6'd4, 1'b0, 20, -1, 100, 100, -1);
        check_window("basic", 16, 16, 6'd20, 1'b1);

        // Re-armed from DONE: the ring pointer carries on from 32
        run_capture("bp", 7'd16, 6'd4, 1'b0, 20, -1, 70, 50, -1);
        check_window("bp", 16, 16, 6'd52, 1'b0);

        do_reset();
        run_capture("wrap", 7'd16, 6'd10, 1'b1, 70, -1, 100, 100, -1);
        check_window("wrap", 60, 16, 6'd6, 1'b1);

        do_reset();
        run_capture("pretrig", 7'd16, 6'd8, 1'b0, 12, 2, 100, 100, -1);
        check_window("pretrig", 4, 16, 6'd12, 1'b1);

        do_reset();
        run_capture("clamp", 7'd0, 6'd63, 1'b0, 70, -1, 100, 100, -1);
        check_window("clamp", 7, 64, 6'd6, 1'b1);

        do_reset();
        run_capture("fullring", 7'd64, 6'd0, 1'b0, 5, -1, 100, 100, -1);
        check_window("fullring", 5, 64, 6'd5, 1'b1);

        do_reset();
        run_capture("midrst", 7'd16, 6'd4, 1'b0, 20, -1, 100, 100, 5);
        aclk_rst      = 1'b1;
        m_axis_tready = 1'b0;
        tick();
        aclk_rst = 1'b0;
        check_val("midrst_tvalid", m_axis_tvalid, 0);
        check_val("midrst_busy", busy, 0);
        check_val("midrst_done", done, 0);
        m_axis_tready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check_val("midrst_count", rx_data.size(), 5);
        any_last = 1'b0;
        foreach (rx_last[i]) any_last |= rx_last[i];
        check_val("midrst_no_tlast", any_last, 0);

        run_capture("rearm", 7'd16, 6'd4, 1'b0, 20, -1, 100, 100, -1);
        check_window("rearm", 16, 16, 6'd20, 1'b1);

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_capture_buffer.md
Name: adc_capture_buffer

Overview:
- Triggered snapshot buffer for one RFDC ADC AXI4-Stream channel: 128-bit beats, 8 samples x 16 bit.
- Sits between the ADC master stream (m*_axis) and the PS-side capture input (S_AXIS_n).
- Continuously records into a block-RAM ring. On trigger it freezes a window of pre-trigger and post-trigger beats, then replays that window as a packet ending in TLAST.

Parameters:
- ADDR_BITS, 10, ring depth DEPTH = 2^ADDR_BITS beats.
- DATA_WIDTH, 128, beat width.

Ports:
- aclk  in  1  stream clock; everything is synchronous to it.
- aclk_rst  in  1  synchronous active-high reset.
- s_axis_tdata  in  DATA_WIDTH  ADC beat.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tready  out  1  constant 1; the ADC is never stalled.
- m_axis_tdata  out  DATA_WIDTH  replayed beat.
- m_axis_tvalid  out  1  replay valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last beat of the window.
- arm  in  1  single-cycle pulse; starts a capture.
- trigger  in  1  single-cycle pulse.
- pretrig_len  in  ADDR_BITS  beats kept before the trigger beat.
- capture_len  in  ADDR_BITS+1  total beats in the window.
- armed  out  1  high in ARMED state.
- busy  out  1  high in PRE, ARMED, POST, READOUT.
- done  out  1  high in DONE state.
- trig_addr  out  ADDR_BITS  ring address of the trigger beat.

Behaviour:
- Reset values: state IDLE; all counters 0; m_axis_tvalid=0, m_axis_tlast=0, armed=0, busy=0, done=0, trig_addr=0. m_axis_tdata is don't-care. s_axis_tready=1 from the first cycle after reset.
- Write path: in PRE, ARMED and POST, every beat with s_axis_tvalid=1 is written at wptr, then wptr increments mod DEPTH. Beats arriving in any other state are discarded. wptr is not reset on arm.
- Parameter latch: on arm accepted in IDLE or DONE, latch C = capture_len and P = pretrig_len.
  - C=0 or C>DEPTH: C becomes DEPTH.
  - P>=C: P becomes C-1.
  - arm in any other state is ignored.
- IDLE/DONE --arm--> PRE, with precnt=0.
  - If P=0, go directly to ARMED instead.
  - done clears on the cycle after arm.
- PRE: precnt counts written beats. Go to ARMED on the cycle the P-th beat is written. trigger is ignored in PRE, so an incomplete pre-window can never be captured.
- ARMED: recording continues, wrapping freely.
  - On trigger=1: trig_addr <= wptr, go to POST with postcnt=0.
  - If s_axis_tvalid=1 that same cycle, that beat is the trigger beat and counts as post beat 1.
  - Otherwise the next valid beat is the trigger beat.
- POST: when postcnt reaches C-P beats written (trigger beat included), compute start = (trig_addr - P) mod DEPTH and go to READOUT. Further trigger pulses are ignored.
- READOUT: read C beats from start upward, wrapping mod DEPTH.
  - BRAM read latency 2 cycles, plus a 2-entry output skid/FIFO so a full-throughput handshake holds under arbitrary m_axis_tready.
  - First m_axis_tvalid appears no later than 3 cycles after READOUT is entered.
  - m_axis_tdata and m_axis_tlast are held stable while tvalid=1 and tready=0.
  - tlast=1 only on beat C.
  - With tready held at 1, C beats go out on C consecutive cycles.
  - Go to DONE the cycle after the beat carrying tlast is accepted.
- DONE: done=1 and tvalid=0 until the next arm.
- Simultaneous arm and trigger in IDLE: arm is taken, trigger is ignored.
- Reset mid-operation (any state): IDLE on the next edge. m_axis_tvalid drops on the next cycle and no tlast is emitted.
- Window size C=DEPTH with P=0: the ring is overwritten exactly once, and the first replayed beat is the trigger beat.

Test Plan:
Common setup: ADDR_BITS=6 (DEPTH 64). Input beat k carries the value k in every 16-bit lane, tvalid continuous unless stated. "Beat k" below means the beat whose value is k.
- Basic: P=4, C=16, arm at beat 0, trigger while beat 20 is presented -> out beats 16..35? No: out = beats 16..31, tlast on beat 31, done=1 afterwards, trig_addr=20.
- Ring wrap: continuous run, arm at beat 0, P=10, C=16, trigger at beat 70 -> out beats 60..75, with the read address crossing 63->0 correctly.
- Backpressure and input gaps: the basic case with s_axis_tvalid random at 70% and m_axis_tready random at 50% -> exactly 16 beats out, in order, no duplicates or drops, data stable while stalled.
- Trigger in PRE: P=8, trigger 3 beats after arm -> ignored, armed still 0. A second trigger at beat 12 -> out beats 4..(4+C-1).
- Clamping: capture_len=0, pretrig_len=63 -> C=64, P=63, 64 beats out, tlast on the trigger beat.
- Reset mid-readout: aclk_rst pulsed after 5 of 16 output beats -> tvalid=0 next cycle, busy=0, done=0, no tlast. A new arm afterwards works normally.
